blake2_core_arbiter: RTL and testbench

- Shares one BLAKE2 core (init/next/final/block/data_length interface) between NUM_CH upstream hashing controllers.
- The core holds chaining state, so ownership is locked per message: granted on an INIT command, released after FINAL's digest is returned.
- Owner is chosen round-robin among channels requesting INIT.
- Sits between the per-stream block controllers and the single blake2 core instance.

---
 rtl/blake2_core_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_blake2_core_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/blake2_core_arbiter.sv
// Round-robin, per-message lock arbiter sharing one BLAKE2 core between NUM_CH hashing controllers.
// Optional idle-owner watchdog enabled by defining BLAKE2_ARB_TIMEOUT_EN.
module blake2_core_arbiter #(
  parameter int NUM_CH         = 2,
  parameter int BLOCK_WIDTH    = 1024,
  parameter int DATA_LENGTH    = 128,
  parameter int DIGEST_WIDTH   = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               ch_valid,
  input  logic [2*NUM_CH-1:0]             ch_op,
  input  logic [BLOCK_WIDTH*NUM_CH-1:0]   ch_block,
  input  logic [DATA_LENGTH*NUM_CH-1:0]   ch_length,
  output logic [NUM_CH-1:0]               ch_ready,
  output logic [DIGEST_WIDTH-1:0]         ch_digest,
  output logic [NUM_CH-1:0]               ch_digest_valid,
  output logic [NUM_CH-1:0]               ch_err,
  output logic                            core_init,
  output logic                            core_next,
  output logic                            core_final,
  output logic [BLOCK_WIDTH-1:0]          core_block,
  output logic [DATA_LENGTH-1:0]          core_length,
  input  logic                            core_ready,
  input  logic [DIGEST_WIDTH-1:0]         core_digest,
  input  logic                            core_digest_valid
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] OP_INIT  = 2'd0;
  localparam logic [1:0] OP_NEXT  = 2'd1;
  localparam logic [1:0] OP_FINAL = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_SETTLE, ST_BUSY, ST_OWNED, ST_DIGEST
  } state_t;

  state_t          state;
  logic [CW-1:0]   owner;
  logic [CW-1:0]   rr_ptr;
  logic [1:0]      op_q;
  logic [CW-1:0]   next_rr;

  logic [NUM_CH-1:0] init_req;
  logic            win_found, bad_found, accept, timeout_hit;
  logic [CW-1:0]   win_ch, bad_ch, acc_ch;
  logic [1:0]      own_op, acc_op;

`ifdef BLAKE2_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   tmo_cnt;
`endif

  assign next_rr = (owner == CW'(NUM_CH - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      init_req[i] = ch_valid[i] && (ch_op[2*i +: 2] == OP_INIT);
  end

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    ch_ready    = '0;
    ch_err      = '0;
    accept      = 1'b0;
    acc_ch      = '0;
    timeout_hit = 1'b0;
    win_found   = 1'b0;
    win_ch      = '0;
    bad_found   = 1'b0;
    bad_ch      = '0;
    own_op      = ch_op[2*int'(owner) +: 2];

    for (int k = 0; k < NUM_CH; k++) begin
      if (!win_found && init_req[(int'(rr_ptr) + k) % NUM_CH]) begin
        win_found = 1'b1;
        win_ch    = CW'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!bad_found && ch_valid[i] && (ch_op[2*i +: 2] != OP_INIT)) begin
        bad_found = 1'b1;
        bad_ch    = CW'(i);
      end
    end

    if (!reset) begin
      unique case (state)
        // The digest strobe cycle is kept quiet so a new INIT lands one cycle after it.
        ST_IDLE: if (ch_digest_valid == '0) begin
          if (win_found && core_ready) begin
            ch_ready[win_ch] = 1'b1;
            accept           = 1'b1;
            acc_ch           = win_ch;
          end else if (bad_found) begin
            ch_ready[bad_ch] = 1'b1;
            ch_err[bad_ch]   = 1'b1;
          end
        end
        ST_OWNED: begin
          if (ch_valid[owner]) begin
            if (own_op == OP_RSVD) begin
              ch_ready[owner] = 1'b1;
              ch_err[owner]   = 1'b1;
            end else if (core_ready) begin
              ch_ready[owner] = 1'b1;
              accept          = 1'b1;
              acc_ch          = owner;
            end
          end
`ifdef BLAKE2_ARB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            ch_err[owner] = 1'b1;
            timeout_hit   = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
    acc_op = ch_op[2*int'(acc_ch) +: 2];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      owner           <= '0;
      rr_ptr          <= '0;
      op_q            <= OP_INIT;
      core_init       <= 1'b0;
      core_next       <= 1'b0;
      core_final      <= 1'b0;
      core_block      <= '0;
      core_length     <= '0;
      ch_digest       <= '0;
      ch_digest_valid <= '0;
    end else begin
      core_init       <= 1'b0;
      core_next       <= 1'b0;
      core_final      <= 1'b0;
      ch_digest_valid <= '0;

      unique case (state)
        ST_ISSUE:  state <= ST_SETTLE;
        ST_SETTLE: state <= ST_BUSY;
        ST_BUSY:   if (core_ready) state <= (op_q == OP_FINAL) ? ST_DIGEST : ST_OWNED;
        ST_OWNED:  if (timeout_hit) begin
          rr_ptr <= next_rr;
          state  <= ST_IDLE;
        end
        ST_DIGEST: if (core_digest_valid) begin
          ch_digest              <= core_digest;
          ch_digest_valid[owner] <= 1'b1;
          rr_ptr                 <= next_rr;
          state                  <= ST_IDLE;
        end
        default: ;
      endcase

      if (accept) begin
        owner       <= acc_ch;
        op_q        <= acc_op;
        core_block  <= ch_block[int'(acc_ch)*BLOCK_WIDTH +: BLOCK_WIDTH];
        core_length <= ch_length[int'(acc_ch)*DATA_LENGTH +: DATA_LENGTH];
        core_init   <= (acc_op == OP_INIT);
        core_next   <= (acc_op == OP_NEXT);
        core_final  <= (acc_op == OP_FINAL);
        state       <= ST_ISSUE;
      end
    end
  end

`ifdef BLAKE2_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset || state != ST_OWNED || ch_ready[owner] || timeout_hit)
      tmo_cnt <= '0;
    else if (!ch_valid[owner])
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_blake2_core_arbiter.sv
// Directed bench for blake2_core_arbiter: grant, lock, digest return, error drops, reset abort, watchdog.
module tb_blake2_core_arbiter;

  localparam logic [1:0] INIT = 2'd0, NEXT = 2'd1, FINAL = 2'd2, RSVD = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    ch_valid;
  logic [3:0]    ch_op;
  logic [2047:0] ch_block;
  logic [255:0]  ch_length;
  logic [1:0]    ch_ready, ch_digest_valid, ch_err;
  logic [511:0]  ch_digest;
  logic          core_init, core_next, core_final;
  logic [1023:0] core_block;
  logic [127:0]  core_length;
  logic          core_ready;
  logic [511:0]  core_digest;
  logic          core_digest_valid;

  logic [1023:0] blk0, blk1;
  logic [127:0]  len0, len1;
  logic [511:0]  dig_a5, dig_5a;
  logic [2:0]    pulses;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;
  assign pulses = {core_init, core_next, core_final};

  blake2_core_arbiter #(.NUM_CH(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .ch_valid(ch_valid), .ch_op(ch_op), .ch_block(ch_block), .ch_length(ch_length),
    .ch_ready(ch_ready), .ch_digest(ch_digest), .ch_digest_valid(ch_digest_valid), .ch_err(ch_err),
    .core_init(core_init), .core_next(core_next), .core_final(core_final),
    .core_block(core_block), .core_length(core_length),
    .core_ready(core_ready), .core_digest(core_digest), .core_digest_valid(core_digest_valid)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] op0, input logic [1:0] op1);
    ch_valid = v;
    ch_op    = {op1, op0};
  endtask

  initial begin
    blk0   = {64{16'h0C00}};
    blk1   = {64{16'h0C11}};
    len0   = 128'd64;
    len1   = 128'd200;
    dig_a5 = {64{8'hA5}};
    dig_5a = {64{8'h5A}};
    ch_block  = {blk1, blk0};
    ch_length = {len1, len0};

    // Reset with every input active: nothing may leak out.
    reset = 1'b1; drive(2'b11, INIT, INIT);
    core_ready = 1'b1; core_digest = dig_a5; core_digest_valid = 1'b1;
    cycle(); #1;
    check("rst_ready", 512'(ch_ready), 512'(2'b00));
    check("rst_err",   512'(ch_err),   512'(2'b00));
    cycle(); #1;
    check("rst_pulses", 512'(pulses), 512'(3'b000));
    check("rst_block",  core_block[511:0], 512'(0));
    check("rst_length", 512'(core_length), 512'(0));
    check("rst_digest", ch_digest, 512'(0));
    check("rst_dv",     512'(ch_digest_valid), 512'(2'b00));

    // ch0 INIT: accept at T, core_init only at T+1.
    cycle(); reset = 1'b0; core_digest_valid = 1'b0; drive(2'b01, INIT, INIT); #1;
    check("t1_ready", 512'(ch_ready), 512'(2'b01));
    check("t1_err",   512'(ch_err),   512'(2'b00));
    cycle(); drive(2'b00, INIT, INIT); #1;
    check("t1_pulse",    512'(pulses), 512'(3'b100));
    check("t1_block_lo", core_block[511:0],    blk0[511:0]);
    check("t1_block_hi", core_block[1023:512], blk0[1023:512]);
    check("t1_length",   512'(core_length), 512'(len0));
    cycle(); #1;
    check("t1_pulse_once", 512'(pulses), 512'(3'b000));
    cycle(); reset = 1'b1;
    cycle(); reset = 1'b0;

    // Both INIT together with rr=0: ch0 wins, ch1 held through the whole message.
    drive(2'b11, INIT, INIT); #1;
    check("t2_grant0", 512'(ch_ready), 512'(2'b01));
    cycle(); drive(2'b10, INIT, INIT); #1;
    check("t2_init",       512'(pulses),   512'(3'b100));
    check("t2_hold_issue", 512'(ch_ready), 512'(2'b00));
    cycle(); #1;
    check("t2_hold_settle", 512'(ch_ready), 512'(2'b00));
    cycle(); #1;
    check("t2_hold_busy", 512'(ch_ready), 512'(2'b00));
    cycle(); drive(2'b11, NEXT, INIT); #1;
    check("t2_next_acc", 512'(ch_ready), 512'(2'b01));
    cycle(); drive(2'b10, NEXT, INIT); #1;
    check("t2_next_pulse", 512'(pulses), 512'(3'b010));
    cycle(); cycle();
    cycle(); drive(2'b11, FINAL, INIT); #1;
    check("t2_final_acc", 512'(ch_ready), 512'(2'b01));
    cycle(); drive(2'b10, FINAL, INIT); #1;
    check("t2_final_pulse", 512'(pulses), 512'(3'b001));
    cycle(); cycle();
    cycle(); core_digest = dig_a5; core_digest_valid = 1'b1; #1;
    check("t2_hold_digest", 512'(ch_ready), 512'(2'b00));
    cycle(); core_digest_valid = 1'b0; core_digest = '0; #1;
    check("t2_dv",        512'(ch_digest_valid), 512'(2'b01));
    check("t2_digest",    ch_digest, dig_a5);
    check("t2_no_grant",  512'(ch_ready), 512'(2'b00));
    cycle(); #1;
    check("t2_dv_once",     512'(ch_digest_valid), 512'(2'b00));
    check("t2_grant1",      512'(ch_ready), 512'(2'b10));
    check("t2_digest_hold", ch_digest, dig_a5);
    cycle(); drive(2'b00, INIT, INIT); #1;
    check("t2_ch1_init",  512'(pulses), 512'(3'b100));
    check("t2_ch1_block", core_block[511:0], blk1[511:0]);

    // ch1 FINAL with core_ready low for 20 cycles after the pulse.
    cycle(); cycle();
    cycle(); drive(2'b10, INIT, FINAL); #1;
    check("t4_final_acc", 512'(ch_ready), 512'(2'b10));
    cycle(); drive(2'b00, INIT, FINAL); core_ready = 1'b0; #1;
    check("t4_final_pulse", 512'(pulses), 512'(3'b001));
    for (int i = 0; i < 20; i++) begin
      cycle(); drive(2'b10, INIT, NEXT); #1;
      check("t4_stall_ready",  512'(ch_ready), 512'(2'b00));
      check("t4_stall_pulses", 512'(pulses),   512'(3'b000));
    end
    cycle(); drive(2'b00, INIT, INIT); core_ready = 1'b1;
    cycle(); core_digest = dig_5a; core_digest_valid = 1'b1;
    cycle(); core_digest_valid = 1'b0; #1;
    check("t4_dv",     512'(ch_digest_valid), 512'(2'b10));
    check("t4_digest", ch_digest, dig_5a);

    // Illegal ops in IDLE are dropped with an error strobe and no core pulse.
    cycle(); drive(2'b10, INIT, NEXT); #1;
    check("t3_ready", 512'(ch_ready), 512'(2'b10));
    check("t3_err",   512'(ch_err),   512'(2'b10));
    cycle(); drive(2'b01, RSVD, INIT); #1;
    check("t3_no_pulse",  512'(pulses),   512'(3'b000));
    check("t3_rsvd_ready", 512'(ch_ready), 512'(2'b01));
    check("t3_rsvd_err",   512'(ch_err),   512'(2'b01));
    cycle(); drive(2'b00, INIT, INIT); #1;
    check("t3_err_clear", 512'(ch_err), 512'(2'b00));
    check("t3_pulse_clr", 512'(pulses), 512'(3'b000));

    // Reset while BUSY on a FINAL aborts the message; a late digest is ignored.
    cycle(); drive(2'b01, INIT, INIT); #1;
    check("t5_grant", 512'(ch_ready), 512'(2'b01));
    cycle(); drive(2'b00, INIT, INIT);
    cycle(); cycle();
    cycle(); drive(2'b01, FINAL, INIT); #1;
    check("t5_final_acc", 512'(ch_ready), 512'(2'b01));
    cycle(); drive(2'b00, INIT, INIT); core_ready = 1'b0;
    cycle();
    cycle(); reset = 1'b1;
    cycle(); reset = 1'b0; #1;
    check("t5_pulses", 512'(pulses), 512'(3'b000));
    check("t5_block",  core_block[511:0], 512'(0));
    check("t5_length", 512'(core_length), 512'(0));
    check("t5_digest", ch_digest, 512'(0));
    check("t5_dv",     512'(ch_digest_valid), 512'(2'b00));
    core_ready = 1'b1; core_digest = dig_a5; core_digest_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(); #1;
      check("t5_no_dv", 512'(ch_digest_valid), 512'(2'b00));
    end
    core_digest_valid = 1'b0;

    // Idle owner with a waiting channel: watchdog release only when enabled.
    cycle(); drive(2'b01, INIT, INIT); #1;
    check("t6_grant0", 512'(ch_ready), 512'(2'b01));
    cycle(); drive(2'b10, INIT, INIT);
    cycle(); cycle();
    for (int k = 1; k <= 17; k++) begin
      logic [1:0] exp_err, exp_rdy;
`ifdef BLAKE2_ARB_TIMEOUT_EN
      exp_err = (k == 16) ? 2'b01 : 2'b00;
      exp_rdy = (k == 17) ? 2'b10 : 2'b00;
`else
      exp_err = 2'b00;
      exp_rdy = 2'b00;
`endif
      cycle(); #1;
      check("t6_err",   512'(ch_err),   512'(exp_err));
      check("t6_ready", 512'(ch_ready), 512'(exp_rdy));
    end
    drive(2'b00, INIT, INIT);
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
